// File: rtl/maze_pkg.sv
// ============================================================================
// maze_pkg : grid geometry, maze bitmaps and start/goal cells for the ROM
// Revision : 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

   localparam int GRID_W    = 20;
   localparam int GRID_H    = 20;
   localparam int MAZE_BITS = GRID_W * GRID_H;

   // Row literals are written with col 19 leftmost, so bit 0 of a row is col 0.
   localparam logic [GRID_W-1:0] ROW_FULL   = 20'b11111111111111111111;
   localparam logic [GRID_W-1:0] ROW_OPEN   = 20'b10000000000000000001;
   localparam logic [GRID_W-1:0] ROW_GAP_R  = 20'b10111111111111111111;
   localparam logic [GRID_W-1:0] ROW_GAP_L  = 20'b11111111111111111101;
   localparam logic [GRID_W-1:0] ROW_GAP_M  = 20'b11111111101111111111;
   localparam logic [GRID_W-1:0] ROW_PILLAR = 20'b10101010101010101011;

   function automatic logic [8:0] cell_idx(input int unsigned row, input int unsigned col);
      return 9'(row * GRID_W + col);
   endfunction

   // Concatenations run from row 19 (MSBs) down to row 0 (LSBs).
   localparam logic [MAZE_BITS-1:0] MAZE_0 = {
      ROW_FULL,  ROW_OPEN, ROW_OPEN,  ROW_GAP_L, ROW_OPEN,
      ROW_GAP_R, ROW_OPEN, ROW_GAP_L, ROW_OPEN,  ROW_GAP_R,
      ROW_OPEN,  ROW_GAP_L, ROW_OPEN, ROW_GAP_R, ROW_OPEN,
      ROW_GAP_L, ROW_OPEN, ROW_GAP_R, ROW_OPEN,  ROW_FULL};
   localparam logic [8:0] MAZE_0_START = cell_idx(1, 1);
   localparam logic [8:0] MAZE_0_END   = cell_idx(18, 18);

   localparam logic [MAZE_BITS-1:0] MAZE_1 = {
      ROW_FULL,  ROW_OPEN, ROW_OPEN,  ROW_GAP_R, ROW_OPEN,
      ROW_GAP_M, ROW_OPEN, ROW_GAP_L, ROW_OPEN,  ROW_GAP_M,
      ROW_OPEN,  ROW_GAP_R, ROW_OPEN, ROW_GAP_M, ROW_OPEN,
      ROW_GAP_L, ROW_OPEN, ROW_GAP_M, ROW_OPEN,  ROW_FULL};
   localparam logic [8:0] MAZE_1_START = cell_idx(1, 18);
   localparam logic [8:0] MAZE_1_END   = cell_idx(18, 1);

   localparam logic [MAZE_BITS-1:0] MAZE_2 = {
      ROW_FULL,  ROW_OPEN, ROW_OPEN,  ROW_OPEN,  ROW_GAP_L,
      ROW_OPEN,  ROW_OPEN, ROW_OPEN,  ROW_OPEN,  ROW_GAP_R,
      ROW_OPEN,  ROW_OPEN, ROW_OPEN,  ROW_OPEN,  ROW_GAP_M,
      ROW_OPEN,  ROW_OPEN, ROW_OPEN,  ROW_OPEN,  ROW_FULL};
   localparam logic [8:0] MAZE_2_START = cell_idx(1, 1);
   localparam logic [8:0] MAZE_2_END   = cell_idx(18, 1);

   localparam logic [MAZE_BITS-1:0] MAZE_3 = {
      ROW_FULL,   ROW_PILLAR, ROW_OPEN,   ROW_PILLAR, ROW_OPEN,
      ROW_PILLAR, ROW_OPEN,   ROW_PILLAR, ROW_OPEN,   ROW_OPEN,
      ROW_OPEN,   ROW_PILLAR, ROW_OPEN,   ROW_PILLAR, ROW_OPEN,
      ROW_PILLAR, ROW_OPEN,   ROW_PILLAR, ROW_OPEN,   ROW_FULL};
   localparam logic [8:0] MAZE_3_START = cell_idx(10, 10);
   localparam logic [8:0] MAZE_3_END   = cell_idx(1, 18);

endpackage

`default_nettype wire

// File: rtl/maze_rom.sv
// ============================================================================
// maze_rom : combinational maze table; entries beyond the fourth reuse layouts
// Revision : 1.0
// ============================================================================
`default_nettype none

module maze_rom
   import maze_pkg::*;
#(
   parameter int NUM_MAZES = 4,
   parameter int POS_W     = 9
) (
   input  logic [7:0]           idx_i,
   output logic [MAZE_BITS-1:0] maze_o,
   output logic [POS_W-1:0]     start_o,
   output logic [POS_W-1:0]     end_o,
   output logic                 in_range_o
);

   always_comb begin
      maze_o  = MAZE_0;
      start_o = POS_W'(MAZE_0_START);
      end_o   = POS_W'(MAZE_0_END);
      case (idx_i[1:0])
         2'd1: begin
            maze_o  = MAZE_1;
            start_o = POS_W'(MAZE_1_START);
            end_o   = POS_W'(MAZE_1_END);
         end
         2'd2: begin
            maze_o  = MAZE_2;
            start_o = POS_W'(MAZE_2_START);
            end_o   = POS_W'(MAZE_2_END);
         end
         2'd3: begin
            maze_o  = MAZE_3;
            start_o = POS_W'(MAZE_3_START);
            end_o   = POS_W'(MAZE_3_END);
         end
         default: ;
      endcase
   end

   assign in_range_o = ({24'd0, idx_i} < 32'(NUM_MAZES));

endmodule

`default_nettype wire

// File: rtl/maze_selector.sv
// ============================================================================
// maze_selector : registers the active maze, loaded from ROM on a send edge
// Config macro  : MAZE_SEL_WRAP_EN (sel taken modulo NUM_MAZES instead of
//                 ignoring out-of-range loads)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module maze_selector
   import maze_pkg::*;
#(
   parameter int NUM_MAZES = 4,
   parameter int POS_W     = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           sel,
   input  logic                 send,
   output logic [MAZE_BITS-1:0] maze,
   output logic [POS_W-1:0]     player_start,
   output logic [POS_W-1:0]     player_end
);

   localparam logic [7:0] C_SEL_MASK = 8'(NUM_MAZES - 1);

   logic                 send_q;
   logic [MAZE_BITS-1:0] maze_q,  maze_d;
   logic [POS_W-1:0]     start_q, start_d;
   logic [POS_W-1:0]     end_q,   end_d;

   logic [7:0]           rom_idx;
   logic [MAZE_BITS-1:0] rom_maze;
   logic [POS_W-1:0]     rom_start;
   logic [POS_W-1:0]     rom_end;
   logic                 rom_in_range;
   logic                 load_pulse;

`ifdef MAZE_SEL_WRAP_EN
   assign rom_idx = sel & C_SEL_MASK;
`else
   assign rom_idx = sel;
`endif

   maze_rom #(
      .NUM_MAZES (NUM_MAZES),
      .POS_W     (POS_W)
   ) u_rom (
      .idx_i      (rom_idx),
      .maze_o     (rom_maze),
      .start_o    (rom_start),
      .end_o      (rom_end),
      .in_range_o (rom_in_range)
   );

   assign load_pulse = send & ~send_q;

   // An out-of-range edge is still consumed: send_q tracks send regardless.
   always_comb begin
      maze_d  = maze_q;
      start_d = start_q;
      end_d   = end_q;
      if (load_pulse && rom_in_range) begin
         maze_d  = rom_maze;
         start_d = rom_start;
         end_d   = rom_end;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         send_q  <= 1'b0;
         maze_q  <= MAZE_0;
         start_q <= POS_W'(MAZE_0_START);
         end_q   <= POS_W'(MAZE_0_END);
      end else begin
         send_q  <= send;
         maze_q  <= maze_d;
         start_q <= start_d;
         end_q   <= end_d;
      end
   end

   assign maze         = maze_q;
   assign player_start = start_q;
   assign player_end   = end_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_selector.sv
// ============================================================================
// tb_maze_selector : directed stimulus with a per-cycle reference model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_maze_selector;
   import maze_pkg::*;

   localparam int NM = 4;
   localparam int PW = 9;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [7:0]     sel;
   logic           send;
   logic [399:0]   maze;
   logic [PW-1:0]  ps;
   logic [PW-1:0]  pe;

   int vectors     = 0;
   int miscompares = 0;

   int exp_start [4] = '{21, 38, 21, 210};
   int exp_end   [4] = '{378, 361, 361, 38};

   int   m_entry = 0;
   logic m_prev  = 1'b0;
   bit   m_valid = 1'b0;

   maze_selector #(.NUM_MAZES(NM), .POS_W(PW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sel          (sel),
      .send         (send),
      .maze         (maze),
      .player_start (ps),
      .player_end   (pe)
   );

   always #5 clk = ~clk;

   function automatic logic [399:0] rom_map(input int e);
      case (e)
         1:       return MAZE_1;
         2:       return MAZE_2;
         3:       return MAZE_3;
         default: return MAZE_0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: which ROM entry should be showing after each edge.
   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         m_entry <= 0;
         m_prev  <= 1'b0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         if (send && !m_prev) begin
`ifdef MAZE_SEL_WRAP_EN
            m_entry <= int'(sel) % NM;
`else
            if (int'(sel) < NM) m_entry <= int'(sel);
`endif
         end
         m_prev <= send;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_maze",  maze, rom_map(m_entry));
         chk("model_start", 400'(ps), 400'(exp_start[m_entry]));
         chk("model_end",   400'(pe), 400'(exp_end[m_entry]));
      end
   end

   task automatic drive(input logic r, input logic [7:0] s, input logic sd);
      rst_n = r;
      sel   = s;
      send  = sd;
      @(posedge clk);
      #2;
   endtask

   task automatic check_invariants(input int e);
      int border_ones;
      border_ones = 0;
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 20; c++)
            if ((r == 0 || r == 19 || c == 0 || c == 19) && maze[r*20 + c] === 1'b1)
               border_ones++;
      chk($sformatf("border_e%0d", e), 400'(border_ones), 400'(76));
      chk($sformatf("start_lt400_e%0d", e), 400'(int'(ps) < 400), 400'(1));
      chk($sformatf("end_lt400_e%0d", e), 400'(int'(pe) < 400), 400'(1));
      if (int'(ps) < 400) chk($sformatf("start_open_e%0d", e), 400'(maze[ps]), 400'(0));
      if (int'(pe) < 400) chk($sformatf("end_open_e%0d", e), 400'(maze[pe]), 400'(0));
      chk($sformatf("start_ne_end_e%0d", e), 400'(ps != pe), 400'(1));
   endtask

   initial begin
      drive(1'b0, 8'd0, 1'b0);
      drive(1'b0, 8'd0, 1'b0);
      chk("rst_start", 400'(ps), 400'(21));
      chk("rst_end",   400'(pe), 400'(378));
      chk("rst_maze",  maze, MAZE_0);

      drive(1'b1, 8'd1, 1'b0);
      chk("pre_edge_start", 400'(ps), 400'(21));
      drive(1'b1, 8'd1, 1'b1);
      chk("edge_start", 400'(ps), 400'(38));
      chk("edge_end",   400'(pe), 400'(361));
      drive(1'b1, 8'd1, 1'b1);
      drive(1'b1, 8'd0, 1'b1);
      drive(1'b1, 8'd0, 1'b1);
      chk("hold_start", 400'(ps), 400'(38));
      drive(1'b1, 8'd0, 1'b0);
      drive(1'b1, 8'd0, 1'b1);
      chk("reedge_start", 400'(ps), 400'(21));

      drive(1'b1, 8'd0, 1'b0);
      drive(1'b1, 8'd5, 1'b1);
`ifdef MAZE_SEL_WRAP_EN
      chk("oor5_start", 400'(ps), 400'(38));
`else
      chk("oor5_start", 400'(ps), 400'(21));
`endif
      drive(1'b1, 8'd5, 0);

      drive(1'b1, 8'd2, 1'b1);
      chk("e2_end", 400'(pe), 400'(361));
      drive(1'b1, 8'd2, 1'b0);
      drive(1'b0, 8'd1, 1'b1);
      chk("rst_vs_load_start", 400'(ps), 400'(21));
      chk("rst_vs_load_end",   400'(pe), 400'(378));
      drive(1'b1, 8'd1, 1'b1);
      chk("post_rst_start", 400'(ps), 400'(38));
      drive(1'b1, 8'd1, 1'b0);

      for (int e = 0; e < NM; e++) begin
         drive(1'b1, 8'(e), 1'b1);
         check_invariants(e);
         drive(1'b1, 8'(e), 1'b0);
      end

      drive(1'b1, 8'd4, 1'b1);
`ifdef MAZE_SEL_WRAP_EN
      chk("oor4_start", 400'(ps), 400'(21));
`else
      chk("oor4_start", 400'(ps), 400'(210));
`endif
      drive(1'b1, 8'd4, 1'b0);
      drive(1'b1, 8'd4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
